// File: rtl/str2num_param_if.sv
// rtl/str2num_param_if.sv - character stream in / conversion result out bundle for str2num_param
interface str2num_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [7:0]       str;
    logic             str_valid;
    logic [WIDTH-1:0] num;
    logic             ready;
    logic             done;
    logic             error;
    logic [1:0]       err_code;

    modport master (
        output start, str, str_valid,
        input  num, ready, done, error, err_code
    );

    modport slave (
        input  start, str, str_valid,
        output num, ready, done, error, err_code
    );
endinterface

// File: rtl/str2num_param.sv
// rtl/str2num_param.sv - parametrised ASCII to integer converter with base prefix and range checks
module str2num_param #(
    parameter int WIDTH  = 32,
    parameter int MAXLEN = 16,
    parameter int SIGNED = 1
) (
    input  logic           clk,
    input  logic           rst,
    str2num_param_if.slave bus
);
    localparam int CW = $clog2(MAXLEN + 1) + 1;
    localparam int AW = WIDTH + 5;

    // Largest magnitudes that still fit the result: unsigned, signed positive, signed negative.
    localparam logic [AW-1:0] LIM_U  = {{5{1'b0}}, {WIDTH{1'b1}}};
    localparam logic [AW-1:0] LIM_SP = {{6{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] LIM_SN = {{5{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREFIX, DIGITS, DRAIN} state_t;

    state_t           state;
    logic [WIDTH:0]   acc;
    logic [4:0]       base;
    logic             neg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] num_q;
    logic             ready_q;
    logic             done_q;
    logic             error_q;
    logic [1:0]       code_q;

    logic [7:0]       ch;
    logic [7:0]       sub;
    logic             is_dig;
    logic             is_dec;
    logic [3:0]       dval;
    logic             dlegal;
    logic [AW-1:0]    nxt;
    logic [AW-1:0]    lim;
    logic [WIDTH-1:0] mag;

    assign ch = bus.str;

    // Decode the incoming character into a digit value and build the next accumulator value.
    always_comb begin
        sub    = 8'h00;
        is_dig = 1'b0;
        is_dec = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            sub    = ch - 8'h30;
            is_dig = 1'b1;
            is_dec = 1'b1;
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            sub    = ch - 8'h37;
            is_dig = 1'b1;
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            sub    = ch - 8'h57;
            is_dig = 1'b1;
        end
        dval   = sub[3:0];
        dlegal = is_dig && ({1'b0, dval} < base);
        nxt    = ({4'b0000, acc} * {{WIDTH{1'b0}}, base}) + {{(WIDTH+1){1'b0}}, dval};
        if (SIGNED == 0)
            lim = LIM_U;
        else
            lim = neg ? LIM_SN : LIM_SP;
        mag = acc[WIDTH-1:0];
    end

    // Conversion FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            base    <= 5'd10;
            neg     <= 1'b0;
            cnt     <= '0;
            num_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                // Start wins over any character presented in the same cycle.
                state   <= PREFIX;
                acc     <= '0;
                base    <= 5'd10;
                neg     <= 1'b0;
                cnt     <= '0;
                ready_q <= 1'b0;
                error_q <= 1'b0;
                code_q  <= 2'b00;
            end else if (bus.str_valid) begin
                case (state)
                    IDLE: begin
                    end
                    PREFIX: begin
                        if (SIGNED != 0 && ch == 8'h2D && !neg) begin
                            neg <= 1'b1;
                        end else if (ch == 8'h42) begin
                            base  <= 5'd2;
                            state <= DIGITS;
                        end else if (ch == 8'h4F) begin
                            base  <= 5'd8;
                            state <= DIGITS;
                        end else if (ch == 8'h44) begin
                            base  <= 5'd10;
                            state <= DIGITS;
                        end else if (ch == 8'h48) begin
                            base  <= 5'd16;
                            state <= DIGITS;
                        end else if (is_dec) begin
                            // Bare decimal digit: implicit base 10, and it is the first digit.
                            base  <= 5'd10;
                            acc   <= {{(WIDTH-3){1'b0}}, dval};
                            cnt   <= {{(CW-1){1'b0}}, 1'b1};
                            num_q <= '0;
                            state <= DIGITS;
                        end else if (ch == 8'h00) begin
                            num_q   <= '0;
                            error_q <= 1'b1;
                            code_q  <= 2'b11;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            code_q <= 2'b01;
                            state  <= DRAIN;
                        end
                    end
                    DIGITS: begin
                        if (ch == 8'h00) begin
                            if (cnt == '0) begin
                                num_q   <= '0;
                                error_q <= 1'b1;
                                code_q  <= 2'b11;
                            end else begin
                                num_q   <= neg ? -mag : mag;
                                error_q <= 1'b0;
                            end
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else if (!dlegal) begin
                            code_q <= 2'b01;
                            state  <= DRAIN;
                        end else if (cnt == CW'(MAXLEN)) begin
                            code_q <= 2'b11;
                            state  <= DRAIN;
                        end else if (nxt > lim) begin
                            code_q <= 2'b10;
                            state  <= DRAIN;
                        end else begin
                            acc <= nxt[WIDTH:0];
                            cnt <= cnt + CW'(1);
                            if (cnt == '0)
                                num_q <= '0;
                        end
                    end
                    DRAIN: begin
                        if (ch == 8'h00) begin
                            num_q   <= '0;
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.num      = num_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.err_code = code_q;
endmodule
